// File: rtl/alarm_trigger.sv
// Alarm trigger: detects the rising edge of alarm/clock-time equality and runs the
// ring / snooze / stop state machine, timed by the 1 Hz enable.
module alarm_trigger #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              one_sec_en,
    input  logic                              AL_ON,
    input  logic                              STOP_al,
    input  logic                              SNOOZE,
    input  logic [1:0]                        a_hour1,
    input  logic [3:0]                        a_hour0,
    input  logic [3:0]                        a_min1,
    input  logic [3:0]                        a_min0,
    input  logic [1:0]                        c_hour1,
    input  logic [3:0]                        c_hour0,
    input  logic [3:0]                        c_min1,
    input  logic [3:0]                        c_min0,
    output logic                              Alarm,
    output logic                              snoozing,
    output logic                              missed,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_left
);

    localparam int RW = $clog2(RING_SECS);
    localparam int SW = $clog2(SNOOZE_SECS);
    localparam int LW = $clog2(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
    localparam logic [LW-1:0] SNZ_MAX   = LW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    state_t          state;
    logic [RW-1:0]   ring_cnt;
    logic [SW-1:0]   snz_cnt;
    logic            match;
    logic            match_q;
    logic            trigger;

    assign match = AL_ON
                 && (a_hour1 == c_hour1) && (a_hour0 == c_hour0)
                 && (a_min1  == c_min1)  && (a_min0  == c_min0);

    // Only the first cycle of a match rings, so a minute-long match fires once.
    assign trigger = match && !match_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            Alarm       <= 1'b0;
            snoozing    <= 1'b0;
            missed      <= 1'b0;
            snooze_left <= SNZ_MAX;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            match_q     <= 1'b1;
        end else begin
            match_q <= match;
            if (STOP_al) begin
                missed <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= RINGING;
                        Alarm       <= 1'b1;
                        ring_cnt    <= '0;
                        snooze_left <= SNZ_MAX;
                    end
                end
                RINGING: begin
                    if (!AL_ON || STOP_al) begin
                        state <= IDLE;
                        Alarm <= 1'b0;
                    end else if (SNOOZE && (snooze_left != '0)) begin
                        state       <= SNOOZED;
                        Alarm       <= 1'b0;
                        snoozing    <= 1'b1;
                        snz_cnt     <= '0;
                        snooze_left <= snooze_left - 1'b1;
                    end else if (one_sec_en) begin
                        if (ring_cnt == RING_LAST) begin
                            state  <= IDLE;
                            Alarm  <= 1'b0;
                            missed <= 1'b1;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                SNOOZED: begin
                    if (!AL_ON || STOP_al) begin
                        state    <= IDLE;
                        snoozing <= 1'b0;
                    end else if (one_sec_en) begin
                        if (snz_cnt == SNZ_LAST) begin
                            state    <= RINGING;
                            snoozing <= 1'b0;
                            Alarm    <= 1'b1;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    Alarm    <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
